// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM stage: access size codes, FSM encoding
// and byte-enable patterns.
package mips_mem_pkg;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } mem_state_t;

   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data memory port: store replication, byte
// enables, load extraction with sign/zero extension, and alignment check.
module lsu_align
   import mips_mem_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misaligned_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      unique case (addr_lo_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      be_o         = BE_WORD;
      wdata_o      = wdata_i;
      rdata_o      = rdata_i;
      misaligned_o = 1'b0;
      case (size_i)
         MEM_BYTE: begin
            be_o    = BE_BYTE0 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
         end
         MEM_HALF: begin
            be_o         = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
            wdata_o      = {2{wdata_i[15:0]}};
            rdata_o      = {{16{signed_i & half_sel[15]}}, half_sel};
            misaligned_o = addr_lo_i[0];
         end
         // word and the reserved code behave identically
         default: misaligned_o = |addr_lo_i;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: drives a req/ack data memory,
// stalls upstream while an access is outstanding, formats load data for WB.
module mem_access_stage
   import mips_mem_pkg::*;
#(
   parameter int TIMEOUT = 256,
   parameter int CNT_W   = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ALUresult_in,
   input  logic [31:0] wdata_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic [1:0]  MemSize_in,
   input  logic        MemSigned_in,
   input  logic        RegDst_in,
   input  logic [4:0]  RegAddrI_in,
   input  logic [4:0]  RegAddrR_in,
   input  logic        RegWrite_in,
   input  logic        MemToReg_in,
   output logic [31:0] ALUresult_out,
   output logic [31:0] mem_out,
   output logic        RegDst_out,
   output logic [4:0]  RegAddrI_out,
   output logic [4:0]  RegAddrR_out,
   output logic        RegWrite_out,
   output logic        MemToReg_out,
   output logic        stall_out,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        align_err,
   output logic        bus_err
);

   mem_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dm_req_q, dm_req_d;
   logic             dm_we_q, dm_we_d;
   logic [31:0]      dm_addr_q, dm_addr_d;
   logic [3:0]       dm_be_q, dm_be_d;
   logic [31:0]      dm_wdata_q, dm_wdata_d;
   logic [31:0]      mem_q, mem_d;
   logic             align_err_q, align_err_d;
   logic             bus_err_q, bus_err_d;
   logic             timeout_q, timeout_d;
   logic [1:0]       lane_q, lane_d;
   logic [1:0]       size_q, size_d;
   logic             signed_q, signed_d;

   logic        in_idle;
   logic        mem_op;
   logic        issue;
   logic        misaligned_op;
   logic        timeout_hit;
   logic        wb_kill;
   logic [1:0]  al_lane;
   logic [1:0]  al_size;
   logic        al_signed;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;
   logic        al_misaligned;

   assign in_idle = (state_q == ST_IDLE);
   assign mem_op  = MemRead_in | MemWrite_in;

   // Live inputs decide the request in IDLE; the latched copy formats the ack data.
   assign al_lane   = in_idle ? ALUresult_in[1:0] : lane_q;
   assign al_size   = in_idle ? MemSize_in        : size_q;
   assign al_signed = in_idle ? MemSigned_in      : signed_q;

   lsu_align u_lsu_align (
      .addr_lo_i    (al_lane),
      .size_i       (al_size),
      .signed_i     (al_signed),
      .wdata_i      (wdata_in),
      .rdata_i      (dm_rdata),
      .be_o         (al_be),
      .wdata_o      (al_wdata),
      .rdata_o      (al_rdata),
      .misaligned_o (al_misaligned)
   );

   assign issue         = in_idle & mem_op & ~al_misaligned;
   assign misaligned_op = in_idle & mem_op &  al_misaligned;
   assign timeout_hit   = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dm_req_d    = dm_req_q;
      dm_we_d     = dm_we_q;
      dm_addr_d   = dm_addr_q;
      dm_be_d     = dm_be_q;
      dm_wdata_d  = dm_wdata_q;
      mem_d       = mem_q;
      align_err_d = 1'b0;
      bus_err_d   = 1'b0;
      timeout_d   = timeout_q;
      lane_d      = lane_q;
      size_d      = size_q;
      signed_d    = signed_q;
      case (state_q)
         ST_IDLE: begin
            timeout_d = 1'b0;
            if (issue) begin
               dm_req_d   = 1'b1;
               dm_we_d    = MemWrite_in;
               dm_addr_d  = word_align(ALUresult_in);
               dm_be_d    = al_be;
               dm_wdata_d = al_wdata;
               lane_d     = ALUresult_in[1:0];
               size_d     = MemSize_in;
               signed_d   = MemSigned_in;
               cnt_d      = '0;
               state_d    = ST_BUSY;
            end else if (misaligned_op) begin
               align_err_d = 1'b1;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (dm_ack) begin
               dm_req_d = 1'b0;
               mem_d    = dm_we_q ? '0 : al_rdata;
               state_d  = ST_DONE;
            end else if (timeout_hit) begin
               dm_req_d  = 1'b0;
               bus_err_d = 1'b1;
               timeout_d = 1'b1;
               mem_d     = '0;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         dm_req_q    <= 1'b0;
         dm_we_q     <= 1'b0;
         dm_addr_q   <= '0;
         dm_be_q     <= BE_NONE;
         dm_wdata_q  <= '0;
         mem_q       <= '0;
         align_err_q <= 1'b0;
         bus_err_q   <= 1'b0;
         timeout_q   <= 1'b0;
         lane_q      <= 2'b00;
         size_q      <= MEM_WORD;
         signed_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dm_req_q    <= dm_req_d;
         dm_we_q     <= dm_we_d;
         dm_addr_q   <= dm_addr_d;
         dm_be_q     <= dm_be_d;
         dm_wdata_q  <= dm_wdata_d;
         mem_q       <= mem_d;
         align_err_q <= align_err_d;
         bus_err_q   <= bus_err_d;
         timeout_q   <= timeout_d;
         lane_q      <= lane_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
      end
   end

   assign stall_out = rst & ((state_q == ST_BUSY) | issue);
   assign mem_out   = (state_q == ST_DONE) ? mem_q : '0;

   // A stalled, misaligned or timed-out instruction must not write back.
   assign wb_kill = stall_out | misaligned_op | ((state_q == ST_DONE) & timeout_q);

   assign ALUresult_out = ALUresult_in;
   assign RegDst_out    = RegDst_in;
   assign RegAddrI_out  = RegAddrI_in;
   assign RegAddrR_out  = RegAddrR_in;
   assign RegWrite_out  = RegWrite_in & ~wb_kill;
   assign MemToReg_out  = MemToReg_in & ~wb_kill;

   assign dm_req    = dm_req_q;
   assign dm_we     = dm_we_q;
   assign dm_addr   = dm_addr_q;
   assign dm_be     = dm_be_q;
   assign dm_wdata  = dm_wdata_q;
   assign align_err = align_err_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a short timeout (TIMEOUT=4);
// the data memory is modelled by driving dm_ack/dm_rdata from the stimulus.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ALUresult_in, wdata_in;
   logic        MemRead_in, MemWrite_in, MemSigned_in;
   logic [1:0]  MemSize_in;
   logic        RegDst_in, RegWrite_in, MemToReg_in;
   logic [4:0]  RegAddrI_in, RegAddrR_in;
   logic [31:0] ALUresult_out, mem_out;
   logic        RegDst_out, RegWrite_out, MemToReg_out;
   logic [4:0]  RegAddrI_out, RegAddrR_out;
   logic        stall_out, dm_req, dm_we, dm_ack, align_err, bus_err;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_be;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT(4), .CNT_W(9)) dut (
      .clk(clk), .rst(rst),
      .ALUresult_in(ALUresult_in), .wdata_in(wdata_in),
      .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .MemSize_in(MemSize_in), .MemSigned_in(MemSigned_in),
      .RegDst_in(RegDst_in), .RegAddrI_in(RegAddrI_in), .RegAddrR_in(RegAddrR_in),
      .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
      .ALUresult_out(ALUresult_out), .mem_out(mem_out),
      .RegDst_out(RegDst_out), .RegAddrI_out(RegAddrI_out), .RegAddrR_out(RegAddrR_out),
      .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
      .stall_out(stall_out), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .align_err(align_err), .bus_err(bus_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      MemRead_in   = 1'b0;
      MemWrite_in  = 1'b0;
      MemSize_in   = 2'b10;
      MemSigned_in = 1'b0;
      wdata_in     = '0;
      RegWrite_in  = 1'b0;
      MemToReg_in  = 1'b0;
   endtask

   // Runs one memory instruction from its first IDLE cycle through DONE.
   // dm_ack is raised in the ack_after-th cycle that dm_req is high.
   task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input int ack_after,
                         input logic [31:0] rdata,
                         output int stalls, output int req_cycles, output logic [31:0] mem_o,
                         output logic rw_done, output logic rw_stall, output logic berr,
                         output logic [31:0] s_addr, output logic [3:0] s_be,
                         output logic [31:0] s_wdata, output logic s_we);
      bit done;
      done = 1'b0;
      MemRead_in = rd; MemWrite_in = wr; MemSize_in = sz; MemSigned_in = sgn;
      ALUresult_in = addr; wdata_in = wd; RegWrite_in = rd; MemToReg_in = rd;
      dm_rdata = rdata;
      stalls = 0; req_cycles = 0; mem_o = 'x; rw_done = 1'b0; rw_stall = 1'b0; berr = 1'b0;
      s_addr = '0; s_be = '0; s_wdata = '0; s_we = 1'b0;
      for (int cyc = 0; cyc < 20 && !done; cyc++) begin
         @(negedge clk);
         if (stall_out) begin
            stalls++;
            if (RegWrite_out | MemToReg_out) rw_stall = 1'b1;
            if (dm_req) begin
               req_cycles++;
               if (req_cycles == 1) begin
                  s_addr = dm_addr; s_be = dm_be; s_wdata = dm_wdata; s_we = dm_we;
               end
               dm_ack = (req_cycles == ack_after);
            end
         end else begin
            done = 1'b1;
            mem_o = mem_out; rw_done = RegWrite_out; berr = bus_err;
         end
         tick();
         dm_ack = 1'b0;
      end
      check("access_completes", {31'b0, done}, 32'd1);
      idle_inputs();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          st, rq;
      logic [31:0] mo, sa, swd;
      logic [3:0]  sbe;
      logic        rwd, rws, be_flag, swe;

      rst = 1'b0;
      idle_inputs();
      dm_ack = 1'b0; dm_rdata = '0;
      RegDst_in = 1'b0; RegAddrI_in = '0; RegAddrR_in = '0;
      // memory op presented during reset must not stall
      MemRead_in = 1'b1; ALUresult_in = 32'h0000_0100;
      #12;
      check("rst_stall",     {31'b0, stall_out}, 32'd0);
      check("rst_dm_req",    {31'b0, dm_req},    32'd0);
      check("rst_dm_we",     {31'b0, dm_we},     32'd0);
      check("rst_dm_addr",   dm_addr,            32'd0);
      check("rst_dm_be",     {28'b0, dm_be},     32'd0);
      check("rst_dm_wdata",  dm_wdata,           32'd0);
      check("rst_align_err", {31'b0, align_err}, 32'd0);
      check("rst_bus_err",   {31'b0, bus_err},   32'd0);
      check("rst_mem_out",   mem_out,            32'd0);
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
      tick();

      // ALU instruction passes straight through
      ALUresult_in = 32'h1234_5678; RegWrite_in = 1'b1; RegDst_in = 1'b1;
      RegAddrI_in = 5'd3; RegAddrR_in = 5'd17;
      @(negedge clk);
      check("pt_alu",      ALUresult_out,         32'h1234_5678);
      check("pt_regwrite", {31'b0, RegWrite_out}, 32'd1);
      check("pt_regdst",   {31'b0, RegDst_out},   32'd1);
      check("pt_addr_i",   {27'b0, RegAddrI_out}, 32'd3);
      check("pt_addr_r",   {27'b0, RegAddrR_out}, 32'd17);
      check("pt_stall",    {31'b0, stall_out},    32'd0);
      check("pt_mem_out",  mem_out,               32'd0);
      check("pt_dm_req",   {31'b0, dm_req},       32'd0);
      tick();
      idle_inputs();

      // sw @0x100, ack in second request cycle
      access(0, 1, 2'b10, 0, 32'h0000_0100, 32'hCAFE_F00D, 2, 32'h0, st, rq, mo, rwd, rws, be_flag, sa, sbe, swd, swe);
      check("sw_stalls",  st,              32'd3);
      check("sw_req",     rq,              32'd2);
      check("sw_addr",    sa,              32'h0000_0100);
      check("sw_be",      {28'b0, sbe},    32'h0000_000F);
      check("sw_wdata",   swd,             32'hCAFE_F00D);
      check("sw_we",      {31'b0, swe},    32'd1);
      check("sw_mem_out", mo,              32'd0);

      // lw @0x100, 2-cycle latency
      access(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF, st, rq, mo, rwd, rws, be_flag, sa, sbe, swd, swe);
      check("lw_stalls",   st,            32'd3);
      check("lw_mem_out",  mo,            32'hDEAD_BEEF);
      check("lw_rw_done",  {31'b0, rwd},  32'd1);
      check("lw_rw_stall", {31'b0, rws},  32'd0);
      check("lw_we",       {31'b0, swe},  32'd0);

      // byte and half loads
      access(1, 0, 2'b00, 1, 32'h0000_0103, 32'h0, 1, 32'h8012_3456, st, rq, mo, rwd, rws, be_flag, sa, sbe, swd, swe);
      check("lb_stalls",  st,            32'd2);
      check("lb_mem_out", mo,            32'hFFFF_FF80);
      check("lb_be",      {28'b0, sbe},  32'h0000_0008);
      check("lb_addr",    sa,            32'h0000_0100);
      access(1, 0, 2'b00, 0, 32'h0000_0103, 32'h0, 1, 32'h8012_3456, st, rq, mo, rwd, rws, be_flag, sa, sbe, swd, swe);
      check("lbu_mem_out", mo,           32'h0000_0080);
      access(1, 0, 2'b00, 1, 32'h0000_0101, 32'h0, 1, 32'h0000_7F00, st, rq, mo, rwd, rws, be_flag, sa, sbe, swd, swe);
      check("lb_pos_mem_out", mo,        32'h0000_007F);
      access(1, 0, 2'b01, 1, 32'h0000_0102, 32'h0, 1, 32'h8001_5555, st, rq, mo, rwd, rws, be_flag, sa, sbe, swd, swe);
      check("lh_mem_out", mo,            32'hFFFF_8001);
      access(1, 0, 2'b01, 0, 32'h0000_0100, 32'h0, 1, 32'h1234_ABCD, st, rq, mo, rwd, rws, be_flag, sa, sbe, swd, swe);
      check("lhu_mem_out", mo,           32'h0000_ABCD);
      check("lhu_be",      {28'b0, sbe}, 32'h0000_0003);

      // sub-word stores
      access(0, 1, 2'b01, 0, 32'h0000_0102, 32'h1234_ABCD, 1, 32'h0, st, rq, mo, rwd, rws, be_flag, sa, sbe, swd, swe);
      check("sh_be",    {28'b0, sbe}, 32'h0000_000C);
      check("sh_wdata", swd,          32'hABCD_ABCD);
      check("sh_addr",  sa,           32'h0000_0100);
      access(0, 1, 2'b00, 0, 32'h0000_0201, 32'h0000_0077, 1, 32'h0, st, rq, mo, rwd, rws, be_flag, sa, sbe, swd, swe);
      check("sb_be",    {28'b0, sbe}, 32'h0000_0002);
      check("sb_wdata", swd,          32'h7777_7777);
      check("sb_addr",  sa,           32'h0000_0200);

      // misaligned lw: bubble now, align_err pulse next cycle
      MemRead_in = 1'b1; MemSize_in = 2'b10; ALUresult_in = 32'h0000_0101;
      RegWrite_in = 1'b1; MemToReg_in = 1'b1;
      @(negedge clk);
      check("mis_stall",    {31'b0, stall_out},    32'd0);
      check("mis_dm_req",   {31'b0, dm_req},       32'd0);
      check("mis_regwrite", {31'b0, RegWrite_out}, 32'd0);
      check("mis_memtoreg", {31'b0, MemToReg_out}, 32'd0);
      tick();
      idle_inputs();
      RegWrite_in = 1'b1;
      @(negedge clk);
      check("mis_align_err", {31'b0, align_err},    32'd1);
      check("mis_next_rw",   {31'b0, RegWrite_out}, 32'd1);
      check("mis_req_after", {31'b0, dm_req},       32'd0);
      tick();
      @(negedge clk);
      check("mis_pulse_end", {31'b0, align_err},    32'd0);
      // reserved size code checks alignment like a word
      MemRead_in = 1'b1; MemSize_in = 2'b11; ALUresult_in = 32'h0000_0102;
      @(negedge clk);
      check("mis_rsv_rw",    {31'b0, RegWrite_out}, 32'd0);
      tick();
      idle_inputs();
      @(negedge clk);
      check("mis_rsv_align", {31'b0, align_err},    32'd1);
      tick();

      // no ack: abort after 4 request cycles
      access(1, 0, 2'b10, 0, 32'h0000_0300, 32'h0, 100, 32'h1111_1111, st, rq, mo, rwd, rws, be_flag, sa, sbe, swd, swe);
      check("to_req",      rq,               32'd4);
      check("to_stalls",   st,               32'd5);
      check("to_bus_err",  {31'b0, be_flag}, 32'd1);
      check("to_rw_done",  {31'b0, rwd},     32'd0);
      check("to_mem_out",  mo,               32'd0);
      @(negedge clk);
      check("to_idle_berr",  {31'b0, bus_err},   32'd0);
      check("to_idle_stall", {31'b0, stall_out}, 32'd0);
      tick();

      // ack in the last allowed cycle wins over timeout
      access(1, 0, 2'b10, 0, 32'h0000_0304, 32'h0, 4, 32'h2222_2222, st, rq, mo, rwd, rws, be_flag, sa, sbe, swd, swe);
      check("tie_req",     rq,               32'd4);
      check("tie_bus_err", {31'b0, be_flag}, 32'd0);
      check("tie_mem_out", mo,               32'h2222_2222);
      check("tie_rw_done", {31'b0, rwd},     32'd1);

      // reset while BUSY abandons the access
      MemRead_in = 1'b1; MemSize_in = 2'b10; ALUresult_in = 32'h0000_0400;
      RegWrite_in = 1'b1; MemToReg_in = 1'b1;
      tick();
      @(negedge clk);
      check("rb_busy_req", {31'b0, dm_req}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("rb_req_drop",   {31'b0, dm_req},    32'd0);
      check("rb_stall_drop", {31'b0, stall_out}, 32'd0);
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
      tick();
      dm_ack = 1'b1; dm_rdata = 32'h5555_5555;
      @(negedge clk);
      check("late_ack_stall", {31'b0, stall_out}, 32'd0);
      check("late_ack_req",   {31'b0, dm_req},    32'd0);
      tick();
      dm_ack = 1'b0;
      @(negedge clk);
      check("late_ack_mem",   mem_out,            32'd0);
      check("late_ack_berr",  {31'b0, bus_err},   32'd0);
      tick();
      access(1, 0, 2'b00, 0, 32'h0000_0402, 32'h0, 1, 32'h00AB_0000, st, rq, mo, rwd, rws, be_flag, sa, sbe, swd, swe);
      check("rec_stalls",  st, 32'd2);
      check("rec_mem_out", mo, 32'h0000_00AB);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
